// File: rtl/cmb_scan_sequencer.sv
// cmb_scan_sequencer: steps the rotation stage and sweeps enabled RF-switch channels with one ADC trigger each per position.
// Ports:
//   clk50_in      - 50 MHz system clock
//   rst_n_in      - asynchronous active-low reset
//   start_in      - one-cycle start pulse, honoured only in IDLE without stop_in
//   stop_in       - one-cycle abort pulse
//   zero_in       - clears rot_count_out while IDLE
//   mode_in       - 0 single revolution, 1 continuous (latched at start)
//   ch_mask_in    - enabled channels (latched at start)
//   stp_clk_out   - stepper step clock
//   rot_clk_out   - one-cycle pulse when the position count wraps to 0
//   rot_count_out - current position 0..NUM_POS-1
//   rf_sw_out     - one-hot RF switch select
//   adc_trg_out   - ADC trigger
//   busy_out      - high while a run is in progress
//   done_out      - one-cycle pulse when a single run completes
module cmb_scan_sequencer #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 10,
    parameter int NUM_POS   = 1000,
    parameter int STEP_HI   = 2500,
    parameter int STEP_LO   = 2500,
    parameter int SETTLE    = 5000,
    parameter int SW_SETTLE = 50,
    parameter int TRG_W     = 4
) (
    input  logic              clk50_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic              stop_in,
    input  logic              zero_in,
    input  logic              mode_in,
    input  logic [NUM_CH-1:0] ch_mask_in,
    output logic              stp_clk_out,
    output logic              rot_clk_out,
    output logic [CNT_W-1:0]  rot_count_out,
    output logic [NUM_CH-1:0] rf_sw_out,
    output logic              adc_trg_out,
    output logic              busy_out,
    output logic              done_out
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam logic [2:0] S_IDLE = 3'd0, S_SW = 3'd1, S_TRIG = 3'd2,
                           S_STH = 3'd3, S_STL = 3'd4, S_SET = 3'd5;

    logic [2:0]        state, ns;
    logic [31:0]       tmr, nt;
    logic [CW-1:0]     ch, nc;
    logic [NUM_CH-1:0] mask;
    logic [CNT_W:0]    pos_done;
    logic [CW:0]       ini, fst, nxt;
    logic              mode, pend, pend_n, adv, done_n, start, wrap;

    // {found, index} of the lowest set mask bit at or above lo
    function automatic logic [CW:0] pick(input logic [NUM_CH-1:0] m, input int lo);
        pick = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i] && i >= lo) pick = {1'b1, CW'(i)};
    endfunction

    assign ini   = pick(ch_mask_in, 0);
    assign fst   = pick(mask, 0);
    assign nxt   = pick(mask, int'(ch) + 1);
    assign start = state == S_IDLE && start_in && !stop_in;
    assign wrap  = rot_count_out == CNT_W'(NUM_POS - 1);

    always_comb begin
        ns     = state;
        nt     = tmr + 32'd1;
        nc     = ch;
        pend_n = pend;
        adv    = 1'b0;
        done_n = 1'b0;
        case (state)
            S_IDLE: begin
                nt = '0;
                if (start) begin
                    ns     = ini[CW] ? S_SW : S_STH;
                    nc     = ini[CW-1:0];
                    pend_n = 1'b0;
                end
            end
            S_SW:
                if (stop_in) ns = S_IDLE;
                else if (tmr == 32'(SW_SETTLE - 1)) begin
                    ns = S_TRIG;
                    nt = '0;
                end
            S_TRIG:
                if (stop_in) ns = S_IDLE;
                else if (tmr == 32'(TRG_W - 1)) begin
                    ns = nxt[CW] ? S_SW : S_STH;
                    nc = nxt[CW-1:0];
                    nt = '0;
                end
            S_STH: begin
                // a stop during the high phase is deferred so the motor finishes the step it began
                if (stop_in) pend_n = 1'b1;
                if (tmr == 32'(STEP_HI - 1)) begin
                    ns = S_STL;
                    nt = '0;
                end
            end
            S_STL:
                if (stop_in && !pend) ns = S_IDLE;
                else if (tmr == 32'(STEP_LO - 1)) begin
                    adv = 1'b1;
                    ns  = pend ? S_IDLE : S_SET;
                    nt  = '0;
                end
            S_SET:
                if (stop_in) ns = S_IDLE;
                else if (tmr == 32'(SETTLE - 1)) begin
                    nt = '0;
                    if (!mode && pos_done == (CNT_W + 1)'(NUM_POS)) begin
                        ns     = S_IDLE;
                        done_n = 1'b1;
                    end else begin
                        ns = fst[CW] ? S_SW : S_STH;
                        nc = fst[CW-1:0];
                    end
                end
            default: ns = S_IDLE;
        endcase
    end

    always_ff @(posedge clk50_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= S_IDLE;
            tmr           <= '0;
            ch            <= '0;
            mask          <= '0;
            mode          <= 1'b0;
            pend          <= 1'b0;
            pos_done      <= '0;
            stp_clk_out   <= 1'b0;
            rot_clk_out   <= 1'b0;
            rot_count_out <= '0;
            rf_sw_out     <= '0;
            adc_trg_out   <= 1'b0;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
        end else begin
            state <= ns;
            tmr   <= nt;
            ch    <= nc;
            pend  <= pend_n;
            if (start) begin
                mask     <= ch_mask_in;
                mode     <= mode_in;
                pos_done <= '0;
            end
            if (adv) begin
                rot_count_out <= wrap ? '0 : rot_count_out + 1'b1;
                pos_done      <= pos_done + 1'b1;
            end else if (state == S_IDLE && zero_in) rot_count_out <= '0;
            // outputs are decoded from the next state so they line up with the state register
            rot_clk_out <= adv && wrap;
            stp_clk_out <= ns == S_STH;
            adc_trg_out <= ns == S_TRIG;
            rf_sw_out   <= (ns == S_SW || ns == S_TRIG) ? NUM_CH'(1) << nc : '0;
            busy_out    <= ns != S_IDLE;
            done_out    <= done_n;
        end
    end
endmodule

// File: tb/tb_cmb_scan_sequencer.sv
// tb_cmb_scan_sequencer: table-driven single runs plus directed abort, zero and reset sequences.
module tb_cmb_scan_sequencer;
    logic       clk = 1'b0, rst_n_in = 1'b0, start_in = 1'b0, stop_in = 1'b0, zero_in = 1'b0, mode_in = 1'b0;
    logic [3:0] ch_mask_in = '0;
    logic       stp_clk_out, rot_clk_out, adc_trg_out, busy_out, done_out;
    logic [9:0] rot_count_out;
    logic [3:0] rf_sw_out;
    int total = 0, bad = 0;

    typedef struct {
        logic       mode;
        logic [3:0] mask;
        int         trg, steps, busy, rot, done;
    } vec_t;
    vec_t tv[4];

    cmb_scan_sequencer #(.NUM_CH(4), .CNT_W(10), .NUM_POS(8), .STEP_HI(2), .STEP_LO(3),
                         .SETTLE(4), .SW_SETTLE(2), .TRG_W(1)) dut (
        .clk50_in(clk), .rst_n_in(rst_n_in), .start_in(start_in), .stop_in(stop_in),
        .zero_in(zero_in), .mode_in(mode_in), .ch_mask_in(ch_mask_in),
        .stp_clk_out(stp_clk_out), .rot_clk_out(rot_clk_out), .rot_count_out(rot_count_out),
        .rf_sw_out(rf_sw_out), .adc_trg_out(adc_trg_out), .busy_out(busy_out), .done_out(done_out));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int trg = 0, stp = 0, bz = 0, rc = 0, dn = 0, rferr = 0;
        int lst[$];
        logic ptrg = 1'b0, pstp = 1'b0;
        logic [9:0] c0 = rot_count_out;
        for (int i = 0; i < 4; i++) if (v.mask[i]) lst.push_back(i);
        mode_in = v.mode;
        ch_mask_in = v.mask;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        mode_in = ~v.mode;
        ch_mask_in = ~v.mask;
        for (int c = 0; c < 1000; c++) begin
            bz += int'(busy_out);
            rc += int'(rot_clk_out);
            dn += int'(done_out);
            if (adc_trg_out && !ptrg) begin
                if (lst.size() == 0 || rf_sw_out !== 4'(1 << lst[trg % lst.size()])) rferr++;
                trg++;
            end
            if (stp_clk_out && !pstp) stp++;
            if (stp_clk_out && rf_sw_out != 0) rferr++;
            if (!busy_out) break;
            ptrg = adc_trg_out;
            pstp = stp_clk_out;
            @(negedge clk);
        end
        @(negedge clk);
        dn += int'(done_out);
        check($sformatf("v%0d trg", id), trg, v.trg);
        check($sformatf("v%0d steps", id), stp, v.steps);
        check($sformatf("v%0d busy", id), bz, v.busy);
        check($sformatf("v%0d rot_clk", id), rc, v.rot);
        check($sformatf("v%0d done", id), dn, v.done);
        check($sformatf("v%0d rf_sw", id), rferr, 0);
        check($sformatf("v%0d count", id), int'(rot_count_out), int'(c0));
    endtask

    initial begin
        int stp, sh, dn, n;
        logic pstp;
        tv[0] = '{1'b0, 4'b0101, 16, 8, 120, 1, 1};
        tv[1] = '{1'b0, 4'b0000, 0, 8, 72, 1, 1};
        tv[2] = '{1'b0, 4'b1111, 32, 8, 168, 1, 1};
        tv[3] = '{1'b0, 4'b0010, 8, 8, 96, 1, 1};

        start_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst busy", int'(busy_out), 0);
        check("rst outs", int'({stp_clk_out, rot_clk_out, adc_trg_out, done_out, rf_sw_out}), 0);
        check("rst count", int'(rot_count_out), 0);
        start_in = 1'b0;
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk);
        check("idle busy", int'(busy_out), 0);

        foreach (tv[i]) run_vec(tv[i], i);

        // continuous, abort requested during the third step-high phase
        mode_in = 1'b1;
        ch_mask_in = 4'b1000;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        stp = 0; sh = 0; dn = 0; pstp = 1'b0;
        for (int c = 0; c < 500 && stp < 3; c++) begin
            if (stp_clk_out && !pstp) stp++;
            sh += int'(stp_clk_out);
            dn += int'(done_out);
            pstp = stp_clk_out;
            if (stp < 3) @(negedge clk);
        end
        check("abort reach", stp, 3);
        stop_in = 1'b1;
        @(negedge clk);
        stop_in = 1'b0;
        n = 0;
        while (busy_out && n < 100) begin
            sh += int'(stp_clk_out);
            dn += int'(done_out);
            n++;
            @(negedge clk);
        end
        check("abort idle", int'(busy_out), 0);
        check("abort count", int'(rot_count_out), 3);
        check("abort stp_hi", sh, 6);
        check("abort done", dn + int'(done_out), 0);
        check("abort sw_trg", int'({rf_sw_out, adc_trg_out, stp_clk_out}), 0);

        // zero while busy is ignored, zero in idle clears
        mode_in = 1'b1;
        ch_mask_in = 4'b0001;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        zero_in = 1'b1;
        @(negedge clk);
        zero_in = 1'b0;
        stop_in = 1'b1;
        @(negedge clk);
        stop_in = 1'b0;
        @(negedge clk);
        check("zero busy", int'(rot_count_out), 3);
        check("stop idle", int'(busy_out), 0);
        zero_in = 1'b1;
        @(negedge clk);
        zero_in = 1'b0;
        check("zero idle", int'(rot_count_out), 0);
        start_in = 1'b1;
        stop_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        stop_in = 1'b0;
        n = 0;
        repeat (4) begin
            n += int'(busy_out);
            @(negedge clk);
        end
        check("start+stop", n, 0);

        // asynchronous reset mid-trigger
        mode_in = 1'b1;
        ch_mask_in = 4'b1111;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        n = 0;
        while (!(adc_trg_out && rot_count_out == 2) && n < 500) begin
            n++;
            @(negedge clk);
        end
        check("rst reach", int'(adc_trg_out), 1);
        rst_n_in = 1'b0;
        #1;
        check("arst trg", int'(adc_trg_out), 0);
        check("arst rf", int'(rf_sw_out), 0);
        check("arst busy", int'(busy_out), 0);
        check("arst count", int'(rot_count_out), 0);
        @(negedge clk);
        rst_n_in = 1'b1;
        @(negedge clk);
        run_vec(tv[0], 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cmb_scan_sequencer.md
Name: cmb_scan_sequencer

Overview:
Parametrised scan sequencer for the CMB controller. It drives the stepper clock, tracks the rotation position, and sweeps N RF-switch channels with one ADC trigger per enabled channel at every position. It sits between the debounced push-button/switch logic and the rot/stp/rf_sw/adc_trg pins of CMB_top. It generalises the fixed 4-channel single-mode behaviour to configurable channel count, position count and timing, and adds single/continuous modes, a channel mask, abort and zeroing.

Parameters:
NUM_CH, 4, number of RF-switch channels (one-hot rf_sw_out width)
CNT_W, 10, rotation counter width
NUM_POS, 1000, positions per revolution (must be ≤ 2**CNT_W, ≥ 2)
STEP_HI, 2500, stp_clk_out high time in clk cycles (≥ 1)
STEP_LO, 2500, stp_clk_out low time in clk cycles (≥ 1)
SETTLE, 5000, mechanical settle cycles after each step (≥ 1)
SW_SETTLE, 50, RF-switch settle cycles before trigger (≥ 1)
TRG_W, 4, adc_trg_out pulse width in cycles (≥ 1)

Ports:
clk50_in  in  1  50 MHz system clock
rst_n_in  in  1  reset, asynchronous, active-low
start_in  in  1  one-cycle start pulse (pre-debounced)
stop_in  in  1  one-cycle abort pulse
zero_in  in  1  clear rotation count (IDLE only)
mode_in  in  1  0 = single revolution, 1 = continuous
ch_mask_in  in  NUM_CH  enabled channels, bit i = channel i
stp_clk_out  out  1  stepper step clock
rot_clk_out  out  1  one-cycle pulse when rot_count wraps to 0
rot_count_out  out  CNT_W  current position 0..NUM_POS-1
rf_sw_out  out  NUM_CH  one-hot RF switch select, 0 = none
adc_trg_out  out  1  ADC trigger
busy_out  out  1  high while not IDLE
done_out  out  1  one-cycle pulse on single-run completion

Behaviour:
- One clock; reset is asynchronous and active-low. All logic is on clk50_in; rst_n_in low forces all state immediately.
- Reset: state IDLE; all outputs 0, including rot_count_out = 0.
- All outputs are registered.
- States: IDLE, SW_WAIT, TRIG, STEP_H, STEP_L, SETTLE.
- IDLE:
  - start_in=1 and stop_in=0: latch mode_in and ch_mask_in; clear the position counter; go to SW_WAIT at the lowest enabled channel, or to STEP_H if the mask is 0. busy_out rises the next cycle.
  - start_in together with stop_in: ignored.
  - zero_in: rot_count_out←0 next cycle. zero_in is ignored outside IDLE.
- SW_WAIT: rf_sw_out = one-hot(current channel) for SW_SETTLE cycles, then TRIG.
- TRIG: adc_trg_out=1 for TRG_W cycles while rf_sw_out is held. Then move to the next higher enabled channel's SW_WAIT; if none remains, go to STEP_H. Disabled channels cost 0 cycles.
- STEP_H: rf_sw_out=0; stp_clk_out=1 for STEP_HI cycles.
- STEP_L: stp_clk_out=0 for STEP_LO cycles. On the last cycle:
  - rot_count ← (rot_count==NUM_POS-1) ? 0 : rot_count+1.
  - rot_clk_out pulses for 1 cycle when the count wraps to 0.
  - positions_done increments.
- SETTLE: wait SETTLE cycles.
  - Single mode, positions_done==NUM_POS: go to IDLE with done_out=1 for that one cycle; busy_out falls the same cycle.
  - Otherwise: return to the first enabled channel, or STEP_H if the mask is 0.
- Per-position time: k·(SW_SETTLE+TRG_W)+STEP_HI+STEP_LO+SETTLE cycles, where k = popcount(mask).
- A single run leaves rot_count_out at its start value.
- Continuous mode never completes on its own and never pulses done_out.
- stop_in while busy:
  - In STEP_H: finish STEP_H and STEP_L, including the count update, then go to IDLE. The motor and count must stay consistent.
  - In any other state: go to IDLE next cycle; rf_sw_out and adc_trg_out are forced to 0.
  - done_out is never pulsed on abort.
- start_in while busy: ignored. Mid-run changes to mode_in and ch_mask_in have no effect until the next start.
- Reset mid-operation: outputs go to 0 immediately and any partial step is discarded.

Test Plan:
Common setup: NUM_CH=4, NUM_POS=8, STEP_HI=2, STEP_LO=3, SETTLE=4, SW_SETTLE=2, TRG_W=1.
1. Reset held, then released -> every output is 0; start_in without a clock edge changes nothing.
2. Single run, mask=4'b0101, count=0 -> 16 adc_trg pulses, rf_sw alternating 0001/0100, 8 stp_clk pulses, busy high exactly 120 cycles, 1 rot_clk pulse, rot_count ends 0, done pulses once.
3. Single run, mask=0 -> no adc_trg, rf_sw stays 0, 8 step pulses, busy high 72 cycles, done pulses once.
4. Continuous run, mask=4'b1000; stop_in during the 3rd STEP_H -> that step completes, rot_count=3, IDLE follows; no done; rf_sw/adc_trg are 0 afterwards.
5. From count=3: zero_in while busy -> ignored; zero_in in IDLE -> count=0. start_in and stop_in in the same cycle -> stays IDLE.
6. Continuous run, mask=4'b1111; rst_n_in low mid-TRIG -> adc_trg, rf_sw, busy and rot_count go to 0 asynchronously; after release, the next start behaves as in scenario 2.
